// File: rtl/c_fpu.sv
// Two-stage truncating adder/subtractor for the 1/11/20 custom float format.
// Stage 1 unpacks, orders and aligns; stage 2 adds, normalises, packs and classifies.
package FPU_types;
    typedef enum logic [1:0] {
        EXACT     = 2'd0,
        OVERFLOW  = 2'd1,
        UNDERFLOW = 2'd2,
        INEXACT   = 2'd3
    } g_eStatus;
endpackage

module c_fpu
    import FPU_types::*;
(
    input  logic        m_clk,
    input  logic        m_reset,
    input  logic [31:0] m_opA,
    input  logic [31:0] m_opB,
    output logic [31:0] m_dataOut,
    output g_eStatus    m_statusOut
);

    typedef struct packed {
        logic        inf;
        logic        inf_sign;
        logic        sign;
        logic        sub;
        logic [10:0] exp;
        logic [20:0] sig_l;
        logic [20:0] sig_s;
        logic        sticky;
    } s1_t;

    s1_t         s1_d, s1_q;
    logic [31:0] dout_d, dout_q;
    g_eStatus    stat_d, stat_q;

    logic [31:0] big, sml;
    logic [10:0] exp_b, exp_s, shamt;
    logic [20:0] sig_s;
    logic [43:0] shifted;

    always_comb begin
        s1_d = '0;
        // Larger magnitude first; {exp,frac} orders magnitudes directly.
        if (m_opB[30:0] > m_opA[30:0]) begin
            big = m_opB;
            sml = m_opA;
        end else begin
            big = m_opA;
            sml = m_opB;
        end
        exp_b   = (big[30:20] == 11'd0) ? 11'd1 : big[30:20];
        exp_s   = (sml[30:20] == 11'd0) ? 11'd1 : sml[30:20];
        sig_s   = {|sml[30:20], sml[19:0]};
        shamt   = exp_b - exp_s;
        shifted = {sig_s, 23'd0} >> shamt;

        s1_d.sign  = big[31];
        s1_d.sub   = big[31] ^ sml[31];
        s1_d.exp   = exp_b;
        s1_d.sig_l = {|big[30:20], big[19:0]};
        if (shamt >= 11'd23) begin
            s1_d.sig_s  = '0;
            s1_d.sticky = |sig_s;
        end else begin
            s1_d.sig_s  = shifted[43:23];
            s1_d.sticky = |shifted[22:0];
        end

        if (&m_opA[30:20]) begin
            s1_d.inf      = 1'b1;
            s1_d.inf_sign = m_opA[31];
        end else if (&m_opB[30:20]) begin
            s1_d.inf      = 1'b1;
            s1_d.inf_sign = m_opB[31];
        end
    end

    logic [21:0] sum;
    logic [20:0] mant;
    logic [11:0] exp_r;
    logic        sticky_r;

    always_comb begin
        dout_d   = '0;
        stat_d   = EXACT;
        sticky_r = s1_q.sticky;
        exp_r    = {1'b0, s1_q.exp};
        if (s1_q.sub)
            sum = {1'b0, s1_q.sig_l} - {1'b0, s1_q.sig_s};
        else
            sum = {1'b0, s1_q.sig_l} + {1'b0, s1_q.sig_s};
        mant = sum[20:0];

        if (!s1_q.sub && sum[21]) begin
            mant     = sum[21:1];
            exp_r    = exp_r + 12'd1;
            sticky_r = sticky_r | sum[0];
        end
        // Normalise left, but never below exponent field 1 (denormal floor).
        for (int i = 0; i < 20; i++) begin
            if (!mant[20] && exp_r > 12'd1) begin
                mant  = mant << 1;
                exp_r = exp_r - 12'd1;
            end
        end
        if (!mant[20])
            exp_r = 12'd0;

        if (s1_q.inf) begin
            dout_d = {s1_q.inf_sign, 11'h7FF, 20'h0};
            stat_d = OVERFLOW;
        end else if (exp_r >= 12'd2047) begin
            dout_d = {s1_q.sign, 11'h7FF, 20'h0};
            stat_d = OVERFLOW;
        end else if (mant == 21'd0) begin
            dout_d = 32'h0;
            stat_d = sticky_r ? INEXACT : EXACT;
        end else begin
            dout_d = {s1_q.sign, exp_r[10:0], mant[19:0]};
            if (exp_r == 12'd0)
                stat_d = UNDERFLOW;
            else if (sticky_r)
                stat_d = INEXACT;
        end
    end

    always_ff @(posedge m_clk) begin
        if (!m_reset) begin
            s1_q   <= '0;
            dout_q <= '0;
            stat_q <= EXACT;
        end else begin
            s1_q   <= s1_d;
            dout_q <= dout_d;
            stat_q <= stat_d;
        end
    end

    assign m_dataOut   = dout_q;
    assign m_statusOut = stat_q;

endmodule

// File: tb/tb_c_fpu.sv
// Directed-vector bench for c_fpu: reset, latency, arithmetic cases, flags and back-to-back flow.
module tb_c_fpu;
    import FPU_types::*;

    logic        m_clk = 1'b0;
    logic        m_reset;
    logic [31:0] m_opA, m_opB;
    logic [31:0] m_dataOut;
    g_eStatus    m_statusOut;

    c_fpu dut (
        .m_clk      (m_clk),
        .m_reset    (m_reset),
        .m_opA      (m_opA),
        .m_opB      (m_opB),
        .m_dataOut  (m_dataOut),
        .m_statusOut(m_statusOut)
    );

    always #5 m_clk = ~m_clk;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] y;
        g_eStatus    st;
    } vec_t;

    vec_t tv[10];
    int   n_chk  = 0;
    int   n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s act=%h exp=%h", tag, act, exp);
    endtask

    initial begin
        tv[0] = '{32'h07F00000, 32'h07F00000, 32'h08000000, EXACT};
        tv[1] = '{32'h08000000, 32'h07F00000, 32'h08080000, EXACT};
        tv[2] = '{32'h07F00000, 32'h87F00000, 32'h00000000, EXACT};
        tv[3] = '{32'h07F80000, 32'h07F80000, 32'h08080000, EXACT};
        tv[4] = '{32'h07F40000, 32'h87F80000, 32'h87D00000, EXACT};
        tv[5] = '{32'h08020000, 32'h08020000, 32'h08120000, EXACT};
        tv[6] = '{32'h7FEFFFFF, 32'h7FEFFFFF, 32'h7FF00000, OVERFLOW};
        tv[7] = '{32'h00000001, 32'h00000001, 32'h00000002, UNDERFLOW};
        tv[8] = '{32'h082FFFFF, 32'h07F00001, 32'h0830FFFF, INEXACT};
        tv[9] = '{32'h07F00000, 32'hFFF00000, 32'hFFF00000, OVERFLOW};

        // Reset with a live operation pending; outputs must clear.
        m_reset = 1'b0;
        m_opA   = 32'h7FEFFFFF;
        m_opB   = 32'h7FEFFFFF;
        repeat (2) @(posedge m_clk);
        #1;
        chk("rst_data", m_dataOut, 32'h0);
        chk("rst_stat", 32'(m_statusOut), 32'(EXACT));

        // First operation after release: reset value holds one edge, result on the second.
        m_reset = 1'b1;
        m_opA   = 32'h07F00000;
        m_opB   = 32'h07F00000;
        @(posedge m_clk);
        #1;
        chk("lat_hold_data", m_dataOut, 32'h0);
        chk("lat_hold_stat", 32'(m_statusOut), 32'(EXACT));
        m_opA = 32'h0;
        m_opB = 32'h0;
        @(posedge m_clk);
        #1;
        chk("lat_data", m_dataOut, 32'h08000000);
        chk("lat_stat", 32'(m_statusOut), 32'(EXACT));
        @(posedge m_clk);
        #1;
        chk("zero_data", m_dataOut, 32'h0);

        // Back-to-back: new operands every cycle, result k checked right after edge k+1.
        for (int j = 0; j <= 10; j++) begin
            if (j < 10) begin
                m_opA = tv[j].a;
                m_opB = tv[j].b;
            end
            @(posedge m_clk);
            #1;
            if (j >= 1) begin
                chk($sformatf("b2b_data%0d", j - 1), m_dataOut, tv[j-1].y);
                chk($sformatf("b2b_stat%0d", j - 1), 32'(m_statusOut), 32'(tv[j-1].st));
            end
        end

        // Reset mid-flight discards the in-flight result.
        m_opA = 32'h7FEFFFFF;
        m_opB = 32'h7FEFFFFF;
        @(posedge m_clk);
        #1;
        m_reset = 1'b0;
        @(posedge m_clk);
        #1;
        m_reset = 1'b1;
        m_opA   = 32'h0;
        m_opB   = 32'h0;
        chk("midrst_data", m_dataOut, 32'h0);
        chk("midrst_stat", 32'(m_statusOut), 32'(EXACT));
        @(posedge m_clk);
        #1;
        chk("postrst_data", m_dataOut, 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
